// File: rtl/ppfifo_axis_pkg.sv
// Shared definitions for the PPFIFO-to-AXIS framer: FSM encodings and TLAST mode selectors.
package ppfifo_axis_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int LAST_MODE_FRAME = 0;
    localparam int LAST_MODE_BLOCK = 1;

endpackage

// File: rtl/axis_out_reg.sv
// Single AXIS output register stage: loads a payload when free or draining, holds it under backpressure.
module axis_out_reg #(
    parameter int PAYLOAD_W = 35
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    input  logic                 ready_i,
    output logic                 accept_o,
    output logic                 valid_o,
    output logic [PAYLOAD_W-1:0] payload_o
);

    logic                 valid_q;
    logic [PAYLOAD_W-1:0] payload_q;

    assign accept_o  = !valid_q || ready_i;
    assign valid_o   = valid_q;
    assign payload_o = payload_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else if (load_i) begin
            valid_q   <= 1'b1;
            payload_q <= payload_i;
        end else if (ready_i) begin
            valid_q   <= 1'b0;
        end
    end

endmodule

// File: rtl/adapter_ppfifo_2_axis_framer.sv
// Drains ping-pong FIFO read blocks into an AXI4-Stream master, adding SOF/TLAST framing
// that is either frame-length based or tied to PPFIFO block ends.
module adapter_ppfifo_2_axis_framer
    import ppfifo_axis_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int STROBE_WIDTH       = DATA_WIDTH / 8,
    parameter int USER_COUNT         = 1,
    parameter int MAP_PPFIFO_TO_USER = 0,
    parameter int SIZE_WIDTH         = 24,
    parameter int LAST_MODE          = 0
) (
    input  logic                             i_axi_clk,
    input  logic                             rst,
    input  logic                             i_enable,
    input  logic [SIZE_WIDTH-1:0]            i_frame_size,
    output logic                             o_frame_done,
    input  logic                             i_ppfifo_rdy,
    output logic                             o_ppfifo_act,
    input  logic [SIZE_WIDTH-1:0]            i_ppfifo_size,
    input  logic [DATA_WIDTH+USER_COUNT-1:0] i_ppfifo_data,
    output logic                             o_ppfifo_stb,
    output logic                             o_axi_valid,
    input  logic                             i_axi_ready,
    output logic [DATA_WIDTH-1:0]            o_axi_data,
    output logic [STROBE_WIDTH-1:0]          o_axi_keep,
    output logic [USER_COUNT-1:0]            o_axi_user,
    output logic                             o_axi_sof,
    output logic                             o_axi_last
);

    localparam int PAYLOAD_W = DATA_WIDTH + USER_COUNT + 2;
    localparam logic [SIZE_WIDTH:0] ONE_X = {{SIZE_WIDTH{1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic                  act_q, act_d;
    logic [SIZE_WIDTH-1:0] r_count_q, r_count_d;
    logic [SIZE_WIDTH-1:0] blk_size_q, blk_size_d;
    logic [SIZE_WIDTH-1:0] r_beat_q, r_beat_d;
    logic [SIZE_WIDTH-1:0] frm_size_q, frm_size_d;
    logic                  first_q, first_d;
    logic                  frame_done_q;

    logic                  org_accept;
    logic [PAYLOAD_W-1:0]  org_payload;
    logic                  word_sof, word_last;
    logic [USER_COUNT-1:0] word_user;
    logic [SIZE_WIDTH:0]   cnt_inc, beat_inc;
    logic [SIZE_WIDTH-1:0] eff_frm;

    generate
        if (MAP_PPFIFO_TO_USER != 0) begin : g_user
            assign word_user = i_ppfifo_data[DATA_WIDTH +: USER_COUNT];
        end else begin : g_nouser
            logic unused_user;
            assign word_user   = '0;
            assign unused_user = ^i_ppfifo_data[DATA_WIDTH +: USER_COUNT];
        end
    endgenerate

    assign o_ppfifo_stb = (state_q == ACTIVE) && (r_count_q < blk_size_q) && org_accept;
    assign cnt_inc      = {1'b0, r_count_q} + ONE_X;
    assign beat_inc     = {1'b0, r_beat_q} + ONE_X;
    // A frame's length is taken from the input only on its first word, so mid-frame edits wait.
    assign eff_frm      = first_q ? i_frame_size : frm_size_q;

    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        r_count_d  = r_count_q;
        blk_size_d = blk_size_q;
        r_beat_d   = r_beat_q;
        frm_size_d = frm_size_q;
        first_d    = first_q;
        word_sof   = 1'b0;
        word_last  = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_enable && i_ppfifo_rdy && !act_q &&
                    (LAST_MODE == LAST_MODE_BLOCK || i_frame_size != '0)) begin
                    state_d    = ACTIVE;
                    act_d      = 1'b1;
                    r_count_d  = '0;
                    blk_size_d = i_ppfifo_size;
                end
            end
            ACTIVE: begin
                if (r_count_q == blk_size_q) begin
                    state_d = RELEASE;
                    act_d   = 1'b0;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (o_ppfifo_stb) begin
            r_count_d = cnt_inc[SIZE_WIDTH-1:0];
            word_sof  = first_q;
            if (LAST_MODE == LAST_MODE_BLOCK) begin
                word_last = (cnt_inc == {1'b0, blk_size_q});
                first_d   = word_last;
            end else begin
                if (first_q) begin
                    frm_size_d = i_frame_size;
                end
                word_last = (beat_inc == {1'b0, eff_frm});
                r_beat_d  = word_last ? '0 : beat_inc[SIZE_WIDTH-1:0];
                first_d   = word_last;
            end
        end
    end

    always_ff @(posedge i_axi_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            act_q        <= 1'b0;
            r_count_q    <= '0;
            blk_size_q   <= '0;
            r_beat_q     <= '0;
            frm_size_q   <= '0;
            first_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            act_q        <= act_d;
            r_count_q    <= r_count_d;
            blk_size_q   <= blk_size_d;
            r_beat_q     <= r_beat_d;
            frm_size_q   <= frm_size_d;
            first_q      <= first_d;
            frame_done_q <= o_axi_valid && i_axi_ready && o_axi_last;
        end
    end

    axis_out_reg #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_org (
        .clk       (i_axi_clk),
        .rst       (rst),
        .load_i    (o_ppfifo_stb),
        .payload_i ({i_ppfifo_data[DATA_WIDTH-1:0], word_user, word_sof, word_last}),
        .ready_i   (i_axi_ready),
        .accept_o  (org_accept),
        .valid_o   (o_axi_valid),
        .payload_o (org_payload)
    );

    assign {o_axi_data, o_axi_user, o_axi_sof, o_axi_last} = org_payload;
    assign o_axi_keep   = '1;
    assign o_ppfifo_act = act_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_adapter_ppfifo_2_axis_framer.sv
// Directed bench for the PPFIFO-to-AXIS framer; frame-mode and block-mode instances share one harness.
module tb_adapter_ppfifo_2_axis_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [23:0] fsz;
    logic [23:0] psize;
    logic [32:0] pdata;
    logic        rdy;
    logic        ready;
    logic        mode;

    logic        f_done, f_act, f_stb, f_valid, f_sof, f_last;
    logic [31:0] f_data;
    logic [3:0]  f_keep;
    logic [0:0]  f_user;
    logic        b_done, b_act, b_stb, b_valid, b_sof, b_last;
    logic [31:0] b_data;
    logic [3:0]  b_keep;
    logic [0:0]  b_user;

    always #5 clk = ~clk;

    adapter_ppfifo_2_axis_framer #(.MAP_PPFIFO_TO_USER(1), .LAST_MODE(0)) dut_f (
        .i_axi_clk(clk), .rst(rst), .i_enable(en), .i_frame_size(fsz), .o_frame_done(f_done),
        .i_ppfifo_rdy(rdy), .o_ppfifo_act(f_act), .i_ppfifo_size(psize), .i_ppfifo_data(pdata),
        .o_ppfifo_stb(f_stb), .o_axi_valid(f_valid), .i_axi_ready(ready), .o_axi_data(f_data),
        .o_axi_keep(f_keep), .o_axi_user(f_user), .o_axi_sof(f_sof), .o_axi_last(f_last));

    adapter_ppfifo_2_axis_framer #(.MAP_PPFIFO_TO_USER(1), .LAST_MODE(1)) dut_b (
        .i_axi_clk(clk), .rst(rst), .i_enable(en), .i_frame_size(fsz), .o_frame_done(b_done),
        .i_ppfifo_rdy(rdy), .o_ppfifo_act(b_act), .i_ppfifo_size(psize), .i_ppfifo_data(pdata),
        .o_ppfifo_stb(b_stb), .o_axi_valid(b_valid), .i_axi_ready(ready), .o_axi_data(b_data),
        .o_axi_keep(b_keep), .o_axi_user(b_user), .o_axi_sof(b_sof), .o_axi_last(b_last));

    wire        done  = mode ? b_done  : f_done;
    wire        act   = mode ? b_act   : f_act;
    wire        stb   = mode ? b_stb   : f_stb;
    wire        valid = mode ? b_valid : f_valid;
    wire        sof   = mode ? b_sof   : f_sof;
    wire        last  = mode ? b_last  : f_last;
    wire [31:0] data  = mode ? b_data  : f_data;
    wire [3:0]  keep  = mode ? b_keep  : f_keep;
    wire [0:0]  user  = mode ? b_user  : f_user;

    int npass = 0, ntot = 0, nfail = 0;
    int cyc = 0;
    int sizes [16];
    int nblk = 0;
    int blk_ptr, wcnt, nstb, nact, ndone, nbeats;
    logic act_prev, valid_seen;
    logic [31:0] bdata [64];
    logic        bsof  [64];
    logic        blast [64];
    logic        buser [64];
    int          bcyc  [64];
    logic        hold_pend;
    logic [35:0] hsnap;
    logic        bp = 1'b0;
    int          pk = 0;
    int          pat [6] = '{1, 0, 0, 1, 0, 1};

    // PPFIFO model: a queue of block sizes, words numbered 0x100 + index, TUSER = index parity.
    assign rdy   = (blk_ptr < nblk);
    assign psize = 24'(sizes[blk_ptr & 15]);
    assign pdata = {wcnt[0], 32'(32'h100 + wcnt)};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            wcnt <= 0; nstb <= 0; nact <= 0; ndone <= 0; nbeats <= 0; blk_ptr <= 0;
            act_prev <= 1'b0; valid_seen <= 1'b0;
        end else begin
            if (stb) begin
                wcnt <= wcnt + 1;
                nstb <= nstb + 1;
            end
            act_prev <= act;
            if (act && !act_prev) begin
                nact    <= nact + 1;
                blk_ptr <= blk_ptr + 1;
            end
            if (done) ndone <= ndone + 1;
            if (valid) valid_seen <= 1'b1;
            if (valid && ready && nbeats < 64) begin
                bdata[nbeats] <= data;
                bsof[nbeats]  <= sof;
                blast[nbeats] <= last;
                buser[nbeats] <= user[0];
                bcyc[nbeats]  <= cyc;
                nbeats        <= nbeats + 1;
            end
        end
    end

    // Outputs presented while stalled must not change until the handshake.
    always @(posedge clk) begin
        if (!rst && hold_pend)
            chk("hold_stable", {28'd0, valid, data, sof, last, user}, {28'd0, 1'b1, hsnap[34:0]});
        hold_pend <= !rst && valid && !ready;
        hsnap     <= {1'b0, data, sof, last, user};
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            ready = bp ? pat[pk % 6][0] : 1'b1;
            pk++;
        end
    endtask

    task automatic do_reset(input logic m);
        @(negedge clk);
        rst = 1'b1; nblk = 0; bp = 1'b0; ready = 1'b1; mode = m; pk = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic add_block(input int s);
        sizes[nblk] = s;
        nblk++;
    endtask

    initial begin
        logic [6:0] sv, lv;
        rst = 1'b1; en = 1'b1; fsz = 24'd8; ready = 1'b1; mode = 1'b0;
        #1;
        chk("reset_async", {act, valid, sof, last, done, stb, user, data}, 64'd0);
        do_reset(1'b0);
        #1;
        chk("reset_state", {act, valid, sof, last, done, stb, user, data}, 64'd0);
        chk("keep_ones", {60'd0, keep}, 64'hF);

        // Frame mode, 8-beat frame over two 4-word blocks.
        fsz = 24'd8; add_block(4); add_block(4);
        tick(30);
        chk("s1_beats", nbeats, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("s1_data%0d", i), bdata[i], 32'h100 + i);
            chk($sformatf("s1_flags%0d", i), {bsof[i], blast[i], buser[i]},
                {i == 0, i == 7, i[0]});
        end
        for (int i = 1; i < 8; i++)
            if (i != 4) chk($sformatf("s1_b2b%0d", i), bcyc[i] - bcyc[i-1], 1);
        chk("s1_acts", nact, 2);
        chk("s1_done", ndone, 1);
        chk("s1_act_idle", act, 0);

        // Frame mode, 3-beat frames inside one 7-word block; frame stays open.
        do_reset(1'b0);
        fsz = 24'd3; add_block(7);
        tick(25);
        chk("s2_beats", nbeats, 7);
        for (int i = 0; i < 7; i++) begin
            sv[i] = bsof[i];
            lv[i] = blast[i];
        end
        chk("s2_sof", sv, 7'b1001001);
        chk("s2_last", lv, 7'b0100100);
        chk("s2_done", ndone, 2);
        fsz = 24'd5; add_block(2);
        tick(20);
        chk("s2_beats2", nbeats, 9);
        chk("s2_b7", {bsof[7], blast[7]}, 2'b00);
        chk("s2_b8", {bsof[8], blast[8], bdata[8]}, {2'b01, 32'h108});
        chk("s2_done2", ndone, 3);

        // Block mode, sizes 5 and 2; frame size ignored.
        do_reset(1'b1);
        fsz = 24'd0; add_block(5); add_block(2);
        tick(30);
        chk("s3_beats", nbeats, 7);
        for (int i = 0; i < 7; i++) begin
            sv[i] = bsof[i];
            lv[i] = blast[i];
        end
        chk("s3_sof", sv, 7'b0100001);
        chk("s3_last", lv, 7'b1010000);
        chk("s3_done", ndone, 2);

        // Backpressure on a 16-word block.
        do_reset(1'b0);
        fsz = 24'd16; bp = 1'b1; add_block(16);
        tick(70);
        chk("s4_beats", nbeats, 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("s4_data%0d", i), bdata[i], 32'h100 + i);
        chk("s4_stb", nstb, 16);
        chk("s4_last", {bsof[0], blast[14], blast[15]}, 3'b101);
        chk("s4_done", ndone, 1);

        // Empty block, then disabled acquisition, then resume.
        do_reset(1'b0);
        bp = 1'b0; fsz = 24'd8; add_block(0);
        tick(10);
        chk("s5_act_pulse", nact, 1);
        chk("s5_no_stb", nstb, 0);
        chk("s5_no_valid", valid_seen, 0);
        en = 1'b0; add_block(4);
        tick(10);
        chk("s5_dis_act", {31'd0, act, nact}, {32'd0, 32'd1});
        chk("s5_dis_stb", nstb, 0);
        en = 1'b1;
        tick(20);
        chk("s5_resume", nbeats, 4);
        chk("s5_resume_sof", {bsof[0], bdata[0]}, {1'b1, 32'h100});

        // Reset in the middle of a 10-beat frame.
        do_reset(1'b0);
        fsz = 24'd10; add_block(10);
        for (int k = 0; k < 50 && nbeats < 3; k++) tick(1);
        chk("s6_reach3", nbeats, 3);
        rst = 1'b1; nblk = 0;
        #1;
        chk("s6_rst_out", {act, valid, sof, last, done, stb, user, data}, 64'd0);
        tick(2);
        rst = 1'b0;
        add_block(10);
        tick(30);
        chk("s6_beats", nbeats, 10);
        chk("s6_first", {bsof[0], blast[0], bdata[0]}, {2'b10, 32'h100});
        chk("s6_last", {bsof[9], blast[9]}, 2'b01);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
